// File: rtl/pipe_chain_pkg.sv
// Shared constants and helpers for the pipe_chain delay line.
// Occupancy width and parameter legality limits live here.
package pipe_chain_pkg;

  localparam int MIN_WIDTH = 1;
  localparam int MIN_DEPTH = 1;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit cfg_ok(input int width, input int depth);
    return (width >= MIN_WIDTH) && (depth >= MIN_DEPTH);
  endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One elastic register slot: valid bit plus data word.
// Data only moves when a real beat arrives; flush drops the valid bit.
module pipe_chain_stage
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_dat,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= up_vld;
      if (up_vld) begin
        dat <= up_dat;
      end
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// Stallable, flushable register pipeline with collapsing bubbles.
// Optional occupancy port occ_o when PIPE_CHAIN_OCC_EN is defined.
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
`ifdef PIPE_CHAIN_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0] occ_o
`endif
);

  if (!cfg_ok(WIDTH, DEPTH)) begin : g_bad_cfg
    $error("pipe_chain: WIDTH and DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH:0]   rdy;

  // A stage can take a beat if it is empty or everything ahead can move.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = ~vld[k] | rdy[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_vld;
    logic [WIDTH-1:0] up_dat;

    if (k == 0) begin : g_head
      assign up_vld = in_valid_i;
      assign up_dat = in_data_i;
    end else begin : g_body
      assign up_vld = vld[k-1];
      assign up_dat = dat[k-1];
    end

    pipe_chain_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush_i),
      .load   (rdy[k]),
      .up_vld (up_vld),
      .up_dat (up_dat),
      .vld    (vld[k]),
      .dat    (dat[k])
    );
  end

  assign in_ready_o  = rdy[0] & ~flush_i;
  assign out_valid_o = vld[DEPTH-1] & ~flush_i;
  assign out_data_o  = dat[DEPTH-1];

`ifdef PIPE_CHAIN_OCC_EN
  localparam int OW = occ_w(DEPTH);

  always_comb begin
    occ_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_o = occ_o + OW'(vld[k]);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed plus random bench for pipe_chain (WIDTH=8, DEPTH=3).
// Reference model tracks each beat's position in the delay line.
module tb_pipe_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_ready_i;
`ifdef PIPE_CHAIN_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  pipe_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i)
`ifdef PIPE_CHAIN_OCC_EN
    ,
    .occ_o       (occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: beats in FIFO order, each with its stage position.
  int         q_pos [$];
  logic [7:0] q_dat [$];
  logic [7:0] got   [$];
  logic       last_acc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef PIPE_CHAIN_OCC_EN
    chk(tag, 32'(occ), 32'(exp));
`endif
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic ordy, input logic fl);
    int         n_pos [$];
    logic [7:0] n_dat [$];
    logic       exp_rdy;
    logic       exp_ov;
    int         p;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
    exp_rdy = !fl && !(q_pos.size() == DEPTH && !ordy);
    exp_ov  = !fl && q_pos.size() > 0 && q_pos[0] == DEPTH - 1;
    chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid_o), 32'(exp_ov));
    if (exp_ov) chk("out_data", 32'(out_data_o), 32'(q_dat[0]));
    chk_occ("occ", q_pos.size());
    if (out_valid_o && ordy && !fl) got.push_back(out_data_o);
    last_acc = v && exp_rdy;
    if (!fl) begin
      for (int j = 0; j < q_pos.size(); j++) begin
        p = q_pos[j];
        if (p == DEPTH - 1) begin
          if (!ordy) begin
            n_pos.push_back(p);
            n_dat.push_back(q_dat[j]);
          end
        end else begin
          // Moves if a free slot lies ahead of it or the sink drains.
          n_pos.push_back((ordy || j < DEPTH - 1 - p) ? p + 1 : p);
          n_dat.push_back(q_dat[j]);
        end
      end
      if (v && exp_rdy) begin
        n_pos.push_back(0);
        n_dat.push_back(d);
      end
    end
    @(posedge clk);
    q_pos = n_pos;
    q_dat = n_dat;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  logic [7:0] exp_seq [$];

  task automatic chk_got(input string tag);
    chk({tag, "_n"}, 32'(got.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(exp_seq[i]));
  endtask

  logic       pend_v;
  logic [7:0] pend_d;

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    last_acc    = 1'b0;

    // Reset held while inputs toggle
    for (int c = 0; c < 3; c++) begin
      in_valid_i  = 1'(c);
      in_data_i   = 8'($urandom);
      out_ready_i = 1'($urandom);
      #1;
      chk("rst_ov", 32'(out_valid_o), 32'd0);
      chk("rst_od", 32'(out_data_o), 32'h00);
      chk("rst_rdy", 32'(in_ready_o), 32'd1);
      chk_occ("rst_occ", 0);
      @(negedge clk);
    end
    rst_n = 1'b1;

    // Streaming
    got.delete();
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    idle(4);
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_got("stream");

    // Latency spot check on a fresh stream
    got.delete();
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_ov", 32'(out_valid_o), 32'd1);
    chk("lat_od", 32'(out_data_o), 32'h01);
    idle(2);

    // Fill and stall
    got.delete();
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    in_valid_i  = 1'b1;
    in_data_i   = 8'hA4;
    out_ready_i = 1'b0;
    #1;
    chk("full_rdy", 32'(in_ready_o), 32'd0);
    chk_occ("full_occ", 3);
    step(1'b1, 8'hA4, 1'b0, 1'b0);
    step(1'b1, 8'hA4, 1'b1, 1'b0);
    idle(4);
    exp_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    chk_got("fill");

    // Bubble collapse
    got.delete();
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("bub_rdy", 32'(in_ready_o), 32'd1);
    chk_occ("bub_occ", 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("bub_ov2", 32'(out_valid_o), 32'd1);
    chk("bub_od2", 32'(out_data_o), 32'h20);
    idle(2);
    exp_seq = '{8'h10, 8'h20};
    chk_got("bubble");

    // Flush with a full chain and a beat on offer
    got.delete();
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hB3, 1'b0, 1'b0);
    in_valid_i  = 1'b1;
    in_data_i   = 8'hFF;
    out_ready_i = 1'b1;
    flush_i     = 1'b1;
    #1;
    chk("fl_ov", 32'(out_valid_o), 32'd0);
    chk("fl_rdy", 32'(in_ready_o), 32'd0);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    #1;
    chk("fl_ov_next", 32'(out_valid_o), 32'd0);
    chk_occ("fl_occ", 0);
    idle(5);
    exp_seq.delete();
    chk_got("flush");

    // Asynchronous reset mid-stream
    got.delete();
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    #1;
    chk("pre_rst_ov", 32'(out_valid_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid_o), 32'd0);
    chk("arst_rdy", 32'(in_ready_o), 32'd1);
    chk_occ("arst_occ", 0);
    q_pos.delete();
    q_dat.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("arst_lat_ov", 32'(out_valid_o), 32'd1);
    chk("arst_lat_od", 32'(out_data_o), 32'h55);
    idle(2);
    exp_seq = '{8'h55};
    chk_got("arst");

    // Random traffic, upstream holds an offer until it is taken
    pend_v = 1'b0;
    pend_d = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pend_v || last_acc) begin
        pend_v = ($urandom_range(0, 3) != 0);
        pend_d = 8'($urandom);
      end
      step(pend_v, pend_d,
           (c < 300) ? ($urandom_range(0, 1) != 0)
                     : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0));
    end
    idle(DEPTH + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
